// File: rtl/udp_payload_packer_pkg.sv
// ---------------------------------------------------------------------------
// udp_pkt_pkg
// Shared definitions for the UDP payload packer and its buffer RAM:
//   - state_t               : packer FSM state encoding
//   - WORD_W                : sample / payload word width in bits
//   - UDP_MAX_PAYLOAD_BYTES : largest UDP payload that fits an untagged
//                             Ethernet frame without IP fragmentation
//   - payload_bytes()       : words -> byte count as carried on tx_byte_num
// ---------------------------------------------------------------------------
package udp_pkt_pkg;

   localparam int WORD_W                = 32;
   localparam int UDP_MAX_PAYLOAD_BYTES = 1472;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      START = 2'd1,
      SEND  = 2'd2,
      GAP   = 2'd3
   } state_t;

   // Byte length of a payload of the given word count, in the 16-bit
   // length format the UDP engine expects.
   function automatic logic [15:0] payload_bytes(input int words);
      return 16'(words * (WORD_W / 8));
   endfunction

endpackage

// File: rtl/udp_payload_packer_ram.sv
// ---------------------------------------------------------------------------
// udp_payload_ram
// Simple dual-port packet buffer, 2^ADDR_W x 32 bits, single clock.
// The array itself has no reset; only the read register can be cleared.
//
// Ports:
//   clk      in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write word
//   rd_en    in   read strobe; rd_data updates on the next rising edge
//   rd_clr   in   synchronous clear of the read register (wins over rd_en)
//   rd_addr  in   read address
//   rd_data  out  registered read word; holds between reads
// ---------------------------------------------------------------------------
module udp_payload_ram
   import udp_pkt_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register: the clear path gives the downstream engine a defined
   // zero word after reset and after reads past the end of the payload.
   always_ff @(posedge clk) begin
      if (rd_clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/udp_payload_packer.sv
// ---------------------------------------------------------------------------
// udp_payload_packer
// Collects PAYLOAD_WORDS 32-bit sample words from the ADC buffer into a
// packet RAM, requests a UDP transmission with a one-cycle start pulse,
// serves words to the UDP engine on its per-word read requests, then waits
// GAP_CYCLES clocks after tx_done before accepting the next packet.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   upstream word strobe
//   in_data      in   upstream sample word
//   in_ready     out  high only while filling
//   tx_start_en  out  one-cycle transmission request
//   tx_byte_num  out  payload length in bytes (constant)
//   tx_req       in   UDP engine asks for the next payload word
//   tx_data      out  payload word, valid the cycle after tx_req
//   tx_done      in   UDP engine finished the frame
//   pkt_cnt      out  completed packets, wraps
//   drop_cnt     out  words offered while not ready, saturates
//   busy         out  high in every state except FILL
// ---------------------------------------------------------------------------
module udp_payload_packer
   import udp_pkt_pkg::*;
#(
   parameter int PAYLOAD_WORDS = 256,
   parameter int ADDR_W        = 9,
   parameter int GAP_CYCLES    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_start_en,
   output logic [15:0]       tx_byte_num,
   input  logic              tx_req,
   output logic [WORD_W-1:0] tx_data,
   input  logic              tx_done,
   output logic [15:0]       pkt_cnt,
   output logic [15:0]       drop_cnt,
   output logic              busy
);

   // Pointers carry one extra bit so the read side can tell "all words
   // sent" (rd_ptr == PAYLOAD_WORDS) apart from address 0.
   localparam int PTR_W = ADDR_W + 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(PAYLOAD_WORDS - 1);
   localparam logic [PTR_W-1:0] PAYLOAD_IDX = PTR_W'(PAYLOAD_WORDS);
   localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [GAP_W-1:0] gap_cnt;

   logic wr_en;
   logic fill_last;
   logic rd_hit;
   logic rd_en;
   logic rd_over;
   logic rd_clr;
   logic gap_last;

   assign tx_byte_num = payload_bytes(PAYLOAD_WORDS);

   assign wr_en     = (state == FILL) && in_valid;
   assign fill_last = wr_en && (wr_ptr == LAST_IDX);
   assign rd_hit    = (state == SEND) && tx_req;
   assign rd_en     = rd_hit && (rd_ptr < PAYLOAD_IDX);
   assign rd_over   = rd_hit && !(rd_ptr < PAYLOAD_IDX);
   assign rd_clr    = rst || rd_over;
   assign gap_last  = (state == GAP) && (gap_cnt == GAP_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and Moore outputs
   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      busy        = 1'b1;
      tx_start_en = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (fill_last) state_nxt = START;
         end
         START: begin
            tx_start_en = 1'b1;
            state_nxt   = SEND;
         end
         SEND: begin
            // A read requested alongside tx_done is still serviced below.
            if (tx_done) state_nxt = GAP;
         end
         GAP: begin
            if (gap_last) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // Pointers, gap timer and statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         gap_cnt  <= '0;
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;

         if (state == GAP) begin
            if (gap_last) begin
               gap_cnt <= '0;
               wr_ptr  <= '0;
               rd_ptr  <= '0;
            end else begin
               gap_cnt <= gap_cnt + 1'b1;
            end
         end

         if ((state == SEND) && tx_done) pkt_cnt <= pkt_cnt + 16'd1;

         if (in_valid && !in_ready) drop_cnt <= sat_inc16(drop_cnt);
      end
   end

   udp_payload_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (tx_data)
   );

endmodule

// File: tb/tb_udp_payload_packer.sv
module tb_udp_payload_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic        tx_req;
   logic [31:0] tx_data;
   logic        tx_done;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   udp_payload_packer #(
      .PAYLOAD_WORDS (4),
      .ADDR_W        (2),
      .GAP_CYCLES    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .tx_start_en (tx_start_en),
      .tx_byte_num (tx_byte_num),
      .tx_req      (tx_req),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .pkt_cnt     (pkt_cnt),
      .drop_cnt    (drop_cnt),
      .busy        (busy)
   );

   // Advance one clock; inputs change and outputs are sampled 1 ns after
   // the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      tx_req   = 1'b0;
      tx_done  = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready",    32'(in_ready),    32'd1);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_start",       32'(tx_start_en), 32'd0);
      chk("rst_tx_data",     tx_data,          32'd0);
      chk("rst_pkt_cnt",     32'(pkt_cnt),     32'd0);
      chk("rst_drop_cnt",    32'(drop_cnt),    32'd0);
      chk("byte_num",        32'(tx_byte_num), 32'd16);

      // Two words, then spurious handshake while filling
      write_word(32'h0000_0001);
      write_word(32'h0000_0002);
      in_valid = 1'b0;
      tx_done  = 1'b1;
      tx_req   = 1'b1;
      step();
      tx_done = 1'b0;
      tx_req  = 1'b0;
      chk("spur_in_ready",   32'(in_ready),    32'd1);
      chk("spur_busy",       32'(busy),        32'd0);
      chk("spur_pkt_cnt",    32'(pkt_cnt),     32'd0);
      chk("spur_tx_data",    tx_data,          32'd0);
      chk("spur_drop_cnt",   32'(drop_cnt),    32'd0);

      // Remaining two words; start pulse one cycle after the 4th write
      write_word(32'h0000_0003);
      chk("fill3_start",     32'(tx_start_en), 32'd0);
      write_word(32'h0000_0004);
      in_valid = 1'b0;
      chk("start_pulse",     32'(tx_start_en), 32'd1);
      chk("start_in_ready",  32'(in_ready),    32'd0);
      chk("start_busy",      32'(busy),        32'd1);
      step();
      chk("start_once",      32'(tx_start_en), 32'd0);

      // Four back-to-back reads then one past the end
      tx_req = 1'b1;
      step();
      chk("rd0",             tx_data,          32'h0000_0001);
      step();
      chk("rd1",             tx_data,          32'h0000_0002);
      step();
      chk("rd2",             tx_data,          32'h0000_0003);
      step();
      chk("rd3",             tx_data,          32'h0000_0004);
      tx_req = 1'b0;
      step();
      chk("rd_hold",         tx_data,          32'h0000_0004);
      tx_req = 1'b1;
      step();
      tx_req = 1'b0;
      chk("rd_over",         tx_data,          32'h0000_0000);

      // Drops through SEND and GAP, tx_done, gap timing
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      repeat (7) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("done_pkt_cnt",    32'(pkt_cnt),     32'd1);
      chk("gap0_in_ready",   32'(in_ready),    32'd0);
      step();
      chk("gap1_in_ready",   32'(in_ready),    32'd0);
      step();
      in_valid = 1'b0;
      chk("gap_end_ready",   32'(in_ready),    32'd1);
      chk("gap_end_busy",    32'(busy),        32'd0);
      chk("drop_cnt_10",     32'(drop_cnt),    32'd10);

      // Second packet, reset after two of four reads
      write_word(32'h0000_000A);
      write_word(32'h0000_000B);
      write_word(32'h0000_000C);
      write_word(32'h0000_000D);
      in_valid = 1'b0;
      chk("p2_start",        32'(tx_start_en), 32'd1);
      step();
      tx_req = 1'b1;
      step();
      chk("p2_rd0",          tx_data,          32'h0000_000A);
      step();
      chk("p2_rd1",          tx_data,          32'h0000_000B);
      tx_req = 1'b0;
      rst    = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_tx_data", tx_data,          32'd0);
      chk("mid_rst_ready",   32'(in_ready),    32'd1);
      chk("mid_rst_busy",    32'(busy),        32'd0);
      chk("mid_rst_start",   32'(tx_start_en), 32'd0);
      chk("mid_rst_pkt",     32'(pkt_cnt),     32'd0);
      chk("mid_rst_drop",    32'(drop_cnt),    32'd0);

      // Fresh fill after reset: start only after four new writes
      write_word(32'h0000_0011);
      chk("f1_start",        32'(tx_start_en), 32'd0);
      write_word(32'h0000_0022);
      chk("f2_start",        32'(tx_start_en), 32'd0);
      write_word(32'h0000_0033);
      chk("f3_start",        32'(tx_start_en), 32'd0);
      write_word(32'h0000_0044);
      in_valid = 1'b0;
      chk("f4_start",        32'(tx_start_en), 32'd1);
      step();
      tx_req = 1'b1;
      step();
      chk("f_rd0",           tx_data,          32'h0000_0011);
      step();
      chk("f_rd1",           tx_data,          32'h0000_0022);
      step();
      chk("f_rd2",           tx_data,          32'h0000_0033);
      // tx_done together with the last read: read serviced, still to GAP
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      tx_req  = 1'b0;
      chk("f_rd3",           tx_data,          32'h0000_0044);
      chk("f_pkt_cnt",       32'(pkt_cnt),     32'd1);
      // tx_req during GAP is ignored
      tx_req = 1'b1;
      step();
      tx_req = 1'b0;
      chk("gap_req_ignored", tx_data,          32'h0000_0044);
      chk("gap_busy",        32'(busy),        32'd1);
      step();
      chk("f_gap_end",       32'(in_ready),    32'd1);

      // Drop counter saturation
      write_word(32'h1);
      write_word(32'h2);
      write_word(32'h3);
      write_word(32'h4);
      // in_valid stays high: every further cycle is a drop
      repeat (65534) step();
      chk("drop_fffe",       32'(drop_cnt),    32'h0000_FFFE);
      step();
      chk("drop_ffff",       32'(drop_cnt),    32'h0000_FFFF);
      repeat (10) step();
      in_valid = 1'b0;
      chk("drop_sat",        32'(drop_cnt),    32'h0000_FFFF);
      chk("sat_pkt_cnt",     32'(pkt_cnt),     32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_payload_packer.md
Name: udp_payload_packer

Overview:
- Sits directly downstream of the ping-pong ADC buffer and upstream of the UDP transmit engine.
- Collects a fixed number of 32-bit sample words into a packet buffer.
- Once the buffer is full, issues a one-cycle start request and feeds the words to the UDP engine on its per-word read requests.
- After the engine reports done, it waits an inter-packet gap and begins refilling.

Parameters:
- PAYLOAD_WORDS, 256, 32-bit words per UDP payload. Legal range 1..368, so payload ≤ 1472 bytes.
- ADDR_W, 9, buffer address width. Must satisfy 2^ADDR_W ≥ PAYLOAD_WORDS.
- GAP_CYCLES, 16, idle clocks between tx_done and reopening the fill window. Legal range ≥ 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word strobe; one word per cycle when high.
- in_data  in  32  upstream sample word.
- in_ready  out  1  high while the block accepts words (FILL state only).
- tx_start_en  out  1  one-cycle pulse requesting a UDP transmission.
- tx_byte_num  out  16  payload length in bytes; constant PAYLOAD_WORDS*4.
- tx_req  in  1  UDP engine requests the next payload word.
- tx_data  out  32  payload word, registered.
- tx_done  in  1  UDP engine finished the frame (one-cycle pulse).
- pkt_cnt  out  16  packets completed; wraps at 16'hFFFF.
- drop_cnt  out  16  words dropped while in_ready=0; saturates at 16'hFFFF.
- busy  out  1  high in every state except FILL.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FILL; wr_ptr=0; rd_ptr=0; gap counter=0.
  - tx_start_en=0; tx_data=0; pkt_cnt=0; drop_cnt=0; busy=0; in_ready=1.
  - tx_byte_num is combinational, so it is valid at all times.
  - Reset mid-packet discards buffer contents; no tx_start_en is emitted afterwards for that packet.
- States: FILL → START → SEND → GAP → FILL.
- FILL:
  - in_ready=1.
  - in_valid=1 writes in_data to mem[wr_ptr] and increments wr_ptr.
  - The write with wr_ptr==PAYLOAD_WORDS-1 moves the state to START on the next cycle.
  - There is no partial-packet flush: a short fill waits indefinitely.
- START:
  - tx_start_en=1 for exactly this one cycle.
  - in_ready=0.
  - Next state: SEND.
- SEND:
  - tx_req=1 at edge N reads mem[rd_ptr]; tx_data holds that word from edge N+1 (1-cycle latency) and rd_ptr increments.
  - Back-to-back tx_req are supported, one word per cycle.
  - tx_req after rd_ptr==PAYLOAD_WORDS: tx_data<=0 and rd_ptr holds.
  - tx_data otherwise holds its last value between requests.
  - tx_done=1 moves to GAP and increments pkt_cnt.
  - When tx_done and tx_req are high in the same cycle, the read is serviced and the state still moves to GAP.
- GAP:
  - Gap counter counts 0..GAP_CYCLES-1.
  - At the terminal count: wr_ptr=0, rd_ptr=0, counter=0, state=FILL.
  - in_ready rises on the first FILL cycle.
- tx_done outside SEND is ignored: no state change, no pkt_cnt change.
- tx_req outside SEND is ignored: tx_data and rd_ptr are unchanged.
- drop_cnt increments on every cycle with in_valid=1 and in_ready=0, in any state, saturating at 16'hFFFF.
- Buffer memory:
  - Simple dual-port: one write port in FILL, one read port in SEND.
  - Reads and writes never overlap in time, so no read-during-write rule is needed.
- tx_byte_num = PAYLOAD_WORDS*4, truncated to 16 bits. The parameter range guarantees no truncation.

Decomposition:
- Shared package `udp_pkt_pkg`:
  - state encoding constants: FILL=2'd0, START=2'd1, SEND=2'd2, GAP=2'd3;
  - UDP_MAX_PAYLOAD_BYTES = 1472;
  - word width constant = 32.
- One sub-module, `udp_payload_ram`:
  - depth 2^ADDR_W × 32 simple dual-port RAM;
  - registered read, 1-cycle latency, single clk, no reset on the array.
- FSM, pointers and counters live in the top module.

Test Plan:
- Fill with PAYLOAD_WORDS=4, GAP_CYCLES=2; in_valid continuous with 32'h0000_0001..32'h0000_0004 → exactly one tx_start_en pulse one cycle after the 4th write; tx_byte_num=16.
- Same setup, then tx_req held high 4 cycles → tx_data shows 1, 2, 3, 4 on the edges following each request; a 5th tx_req yields 32'h0.
- Drop counting: tx_done pulse during SEND; in_valid held high through START/SEND/GAP for 10 cycles → pkt_cnt=1, drop_cnt=10; in_ready returns high exactly 2 cycles after tx_done.
- Spurious handshake: tx_done and tx_req pulsed while in FILL with 2 words written → no state change, pkt_cnt=0, tx_data unchanged, wr_ptr continues from 2.
- Reset mid-packet: rst asserted for 1 cycle in SEND after 2 of 4 reads → all outputs at reset values next cycle; next tx_start_en only after 4 fresh writes.
- Long run: drop_cnt forced toward 16'hFFFF by >65535 dropped words → holds at 16'hFFFF.
